// File: rtl/ising_pkg.sv
// Shared types and helpers for the Ising energy evaluator.
// Holds the FSM state type, the spin type and the width/rounding helpers.
package ising_pkg;

    // Evaluator sequencing states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        QUANT = 2'd1,
        ACCUM = 2'd2,
        DONE  = 2'd3
    } state_t;

    // One spin: 0 encodes s=+1, 1 encodes s=-1.
    typedef logic spin_t;

    // Default fraction used by the oscillator datapath.
    localparam int FRAC_BITS_DEF = 16;

    // Accumulator width that cannot overflow for N*N terms.
    function automatic int energy_width(input int dw, input int n);
        return dw + $clog2(n * n);
    endfunction

    // Rounding offset of one half in the given fraction.
    function automatic int half_of(input int fb);
        return 1 << (fb - 1);
    endfunction

endpackage

// File: rtl/ising_pair_counter.sv
// Upper-triangle pair index generator for the energy accumulator.
// Walks (0,1),(0,2)..(N-2,N-1) one pair per advance.
module ising_pair_counter #(
    parameter int N  = 16,
    parameter int IW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          advance,
    output logic [IW-1:0] i,
    output logic [IW-1:0] j,
    output logic          last
);

    localparam logic [IW-1:0] LAST_I = IW'(N - 2);
    localparam logic [IW-1:0] LAST_J = IW'(N - 1);
    localparam logic [IW-1:0] ONE    = IW'(1);
    localparam logic [IW-1:0] TWO    = IW'(2);

    assign last = (i == LAST_I) && (j == LAST_J);

    // Restart at (0,1) on load or after the final pair, else step the pair.
    always_ff @(posedge clk) begin
        if (rst || load || (advance && last)) begin
            i <= '0;
            j <= ONE;
        end else if (advance) begin
            if (j == LAST_J) begin
                i <= i + ONE;
                j <= i + TWO;
            end else begin
                j <= j + ONE;
            end
        end
    end

endmodule

// File: rtl/ising_energy_eval.sv
// Ising energy evaluator: quantize phases to spins, then sum -J_ij*s_i*s_j.
// Optional best-result tracking is enabled by defining ISING_BEST_TRACK_EN.
module ising_energy_eval
    import ising_pkg::*;
#(
    parameter int N              = 16,
    parameter int fractionalBits = FRAC_BITS_DEF,
    parameter int dataWidth      = 32,
    parameter int energyWidth    = energy_width(dataWidth, N)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [dataWidth-1:0]   finalPhases    [N],
    input  logic [dataWidth-1:0]   couplingMatrix [N][N],
`ifdef ISING_BEST_TRACK_EN
    input  logic                   clearBest,
    output logic [energyWidth-1:0] bestEnergy,
    output logic [N-1:0]           bestSpins,
`endif
    output logic [N-1:0]           spins,
    output logic [energyWidth-1:0] energy,
    output logic                   busy,
    output logic                   done
);

    localparam int IW = $clog2(N);
    localparam int XW = energyWidth - dataWidth;

    localparam logic [dataWidth-1:0] HALF = dataWidth'(half_of(fractionalBits));
    localparam logic [dataWidth-1:0] LSB  = dataWidth'(1);

    state_t state;
    state_t state_nxt;

    logic [IW-1:0] pi;
    logic [IW-1:0] pj;
    logic          last;

    spin_t [N-1:0] spin_d;
    spin_t [N-1:0] spin_q;

    logic [dataWidth-1:0]   j_val;
    logic [energyWidth-1:0] j_ext;
    logic                   same;
    logic [energyWidth-1:0] acc_q;
    logic [energyWidth-1:0] acc_nxt;
    logic [energyWidth-1:0] energy_q;
    logic                   finish;

    ising_pair_counter #(
        .N  (N),
        .IW (IW)
    ) u_pairs (
        .clk     (clk),
        .rst     (rst),
        .load    (state == QUANT),
        .advance (state == ACCUM),
        .i       (pi),
        .j       (pj),
        .last    (last)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; start only matters in IDLE.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = QUANT;
            QUANT:   state_nxt = ACCUM;
            ACCUM:   if (last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Status outputs decoded from state.
    always_comb begin
        busy = (state == QUANT) || (state == ACCUM);
        done = (state == DONE);
    end

    // Round each phase to nearest integer; odd integer means s=-1.
    always_comb begin
        spin_d = '0;
        for (int k = 0; k < N; k++) begin
            spin_d[k] = (((finalPhases[k] + HALF) >> fractionalBits) & LSB) != '0;
        end
    end

    assign j_val   = couplingMatrix[pi][pj];
    assign j_ext   = {{XW{j_val[dataWidth-1]}}, j_val};
    assign same    = (spin_q[pi] == spin_q[pj]);
    assign finish  = (state == ACCUM) && last;

    // Aligned spins lower the energy by J, opposed spins raise it.
    always_comb begin
        acc_nxt = same ? (acc_q - j_ext) : (acc_q + j_ext);
    end

    // Spin capture, accumulation and result load on entry to DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            spin_q   <= '0;
            acc_q    <= '0;
            energy_q <= '0;
        end else begin
            if (state == QUANT) begin
                spin_q <= spin_d;
                acc_q  <= '0;
            end
            if (state == ACCUM) begin
                acc_q <= acc_nxt;
            end
            if (finish) begin
                energy_q <= acc_nxt;
            end
        end
    end

    assign spins  = spin_q;
    assign energy = energy_q;

`ifdef ISING_BEST_TRACK_EN
    logic                   best_valid;
    logic [energyWidth-1:0] best_e;
    logic [N-1:0]           best_s;
    logic                   take;

    assign take = finish &&
                  (!best_valid || clearBest ||
                   ($signed(acc_nxt) < $signed(best_e)));

    // Keep the strictly lowest energy seen; a new result beats a clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            best_valid <= 1'b0;
            best_e     <= '0;
            best_s     <= '0;
        end else if (take) begin
            best_valid <= 1'b1;
            best_e     <= acc_nxt;
            best_s     <= spin_q;
        end else if (clearBest) begin
            best_valid <= 1'b0;
        end
    end

    assign bestEnergy = best_e;
    assign bestSpins  = best_s;
`endif

endmodule

// File: tb/tb_ising_energy_eval.sv
// Directed bench for ising_energy_eval with N=4.
// Define ISING_BEST_TRACK_EN to also exercise best-result tracking.
module tb_ising_energy_eval;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int EW = DW + $clog2(N * N);

    localparam logic [EW-1:0] E_M6 = EW'(-393216);
    localparam logic [EW-1:0] E_P2 = EW'(131072);
    localparam logic [EW-1:0] E_W  = EW'(409600);

    localparam logic [DW-1:0] ONE_P = 32'h0001_0000;
    localparam logic [DW-1:0] JUNK  = 32'h1234_5678;

    logic          clk;
    logic          rst;
    logic          start;
    logic [DW-1:0] phases [N];
    logic [DW-1:0] jm     [N][N];
    logic [N-1:0]  spins;
    logic [EW-1:0] energy;
    logic          busy;
    logic          done;
`ifdef ISING_BEST_TRACK_EN
    logic          clear_best;
    logic [EW-1:0] best_energy;
    logic [N-1:0]  best_spins;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    ising_energy_eval #(
        .N              (N),
        .fractionalBits (16),
        .dataWidth      (DW),
        .energyWidth    (EW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .finalPhases    (phases),
        .couplingMatrix (jm),
`ifdef ISING_BEST_TRACK_EN
        .clearBest      (clear_best),
        .bestEnergy     (best_energy),
        .bestSpins      (best_spins),
`endif
        .spins          (spins),
        .energy         (energy),
        .busy           (busy),
        .done           (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_phases(input logic [DW-1:0] a, input logic [DW-1:0] b,
                              input logic [DW-1:0] c, input logic [DW-1:0] d);
        phases[0] = a;
        phases[1] = b;
        phases[2] = c;
        phases[3] = d;
    endtask

    task automatic set_j_all(input logic [DW-1:0] v);
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                jm[r][c] = (r < c) ? v : JUNK;
    endtask

    // One idle cycle, then a one-cycle start; returns in cycle k+1.
    task automatic do_start();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Counts cycles after the start edge until done (bounded).
    task automatic wait_done(output int lat, output int busy_n);
        lat    = 1;
        busy_n = 0;
        while (!done && lat < 100) begin
            if (busy) busy_n++;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (spins !== 4'b0000) begin
            n_fail++; $display("FAIL reset_spins: got %b expected 0000", spins);
        end
        n_checks++;
        if (energy !== '0) begin
            n_fail++; $display("FAIL reset_energy: got %0d expected 0", $signed(energy));
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_busy: got %b expected 0", busy);
        end
        n_checks++;
        if (done !== 1'b0) begin
            n_fail++; $display("FAIL reset_done: got %b expected 0", done);
        end
        rst = 1'b0;
    endtask

    task automatic test_all_aligned();
        int lat, bn;
        set_phases(0, 0, 0, 0);
        set_j_all(ONE_P);
        do_start();
        wait_done(lat, bn);
        n_checks++;
        if (lat !== 8 || done !== 1'b1) begin
            n_fail++; $display("FAIL aligned_latency: got %0d expected 8", lat);
        end
        n_checks++;
        if (bn !== 7) begin
            n_fail++; $display("FAIL aligned_busy_cycles: got %0d expected 7", bn);
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL aligned_busy_in_done: got %b expected 0", busy);
        end
        n_checks++;
        if (energy !== E_M6) begin
            n_fail++; $display("FAIL aligned_energy: got %0d expected -393216", $signed(energy));
        end
        n_checks++;
        if (spins !== 4'b0000) begin
            n_fail++; $display("FAIL aligned_spins: got %b expected 0000", spins);
        end
        @(posedge clk); #1;
        n_checks++;
        if (done !== 1'b0 || energy !== E_M6) begin
            n_fail++;
            $display("FAIL aligned_hold: got done=%b e=%0d expected done=0 e=-393216",
                     done, $signed(energy));
        end
    endtask

    task automatic test_alternating();
        int lat, bn;
        set_phases(0, ONE_P, 0, ONE_P);
        set_j_all(ONE_P);
        do_start();
        wait_done(lat, bn);
        n_checks++;
        if (done !== 1'b1 || energy !== E_P2) begin
            n_fail++;
            $display("FAIL alt_energy: got done=%b e=%0d expected done=1 e=131072",
                     done, $signed(energy));
        end
        n_checks++;
        if (spins !== 4'b1010) begin
            n_fail++; $display("FAIL alt_spins: got %b expected 1010", spins);
        end
    endtask

    task automatic test_weighted();
        int lat, bn;
        set_phases(0, ONE_P, 0, ONE_P);
        set_j_all(JUNK);
        jm[0][1] = 32'h0001_0000;
        jm[0][2] = 32'hFFFF_8000;
        jm[0][3] = 32'h0002_0000;
        jm[1][2] = 32'h0000_4000;
        jm[1][3] = 32'hFFFF_0000;
        jm[2][3] = 32'h0001_8000;
        do_start();
        wait_done(lat, bn);
        n_checks++;
        if (done !== 1'b1 || energy !== E_W) begin
            n_fail++;
            $display("FAIL weighted_energy: got done=%b e=%0d expected done=1 e=409600",
                     done, $signed(energy));
        end
    endtask

    task automatic test_rounding();
        int lat, bn;
        set_phases(32'h0000_7D70, 32'h0000_8000, 32'hFFFF_6666, 32'h0002_0000);
        set_j_all(ONE_P);
        do_start();
        wait_done(lat, bn);
        n_checks++;
        if (spins !== 4'b0110) begin
            n_fail++; $display("FAIL round_spins: got %b expected 0110", spins);
        end
        n_checks++;
        if (done !== 1'b1 || energy !== E_P2) begin
            n_fail++;
            $display("FAIL round_energy: got done=%b e=%0d expected done=1 e=131072",
                     done, $signed(energy));
        end
    endtask

    task automatic test_ignore_start();
        int n_done;
        logic [EW-1:0] got_e;
        n_done = 0;
        got_e  = '0;
        set_phases(0, 0, 0, 0);
        set_j_all(ONE_P);
        do_start();
        @(posedge clk); #1;
        start    = 1'b1;
        jm[1][0] = 32'h7FFF_FFFF;
        jm[2][2] = 32'h8000_0000;
        jm[3][1] = 32'h0005_0000;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 0; c < 30; c++) begin
            if (done) begin
                n_done++;
                got_e = energy;
                start = 1'b1;
            end
            @(posedge clk); #1;
            start = 1'b0;
        end
        n_checks++;
        if (n_done !== 1) begin
            n_fail++; $display("FAIL ignore_done_count: got %0d expected 1", n_done);
        end
        n_checks++;
        if (got_e !== E_M6) begin
            n_fail++; $display("FAIL ignore_energy: got %0d expected -393216", $signed(got_e));
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL ignore_idle: got busy=%b expected 0", busy);
        end
    endtask

    task automatic test_mid_reset();
        int lat, bn, n_done;
        set_phases(0, ONE_P, 0, ONE_P);
        set_j_all(ONE_P);
        do_start();
        repeat (3) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++; $display("FAIL midrst_status: got busy=%b done=%b expected 0 0", busy, done);
        end
        n_checks++;
        if (energy !== '0 || spins !== '0) begin
            n_fail++;
            $display("FAIL midrst_outputs: got e=%0d spins=%b expected 0 0000",
                     $signed(energy), spins);
        end
        n_done = 0;
        for (int c = 0; c < 12; c++) begin
            if (done) n_done++;
            @(posedge clk); #1;
        end
        n_checks++;
        if (n_done !== 0) begin
            n_fail++; $display("FAIL midrst_no_done: got %0d expected 0", n_done);
        end
        do_start();
        wait_done(lat, bn);
        n_checks++;
        if (done !== 1'b1 || energy !== E_P2 || spins !== 4'b1010) begin
            n_fail++;
            $display("FAIL midrst_rerun: got done=%b e=%0d spins=%b expected 1 131072 1010",
                     done, $signed(energy), spins);
        end
    endtask

`ifdef ISING_BEST_TRACK_EN
    task automatic test_best();
        int lat, bn;
        set_j_all(ONE_P);
        @(posedge clk); #1;
        clear_best = 1'b1;
        @(posedge clk); #1;
        clear_best = 1'b0;
        set_phases(0, 0, 0, 0);
        do_start();
        wait_done(lat, bn);
        set_phases(0, ONE_P, 0, ONE_P);
        do_start();
        wait_done(lat, bn);
        n_checks++;
        if (best_energy !== E_M6 || best_spins !== 4'b0000) begin
            n_fail++;
            $display("FAIL best_after_worse: got %0d/%b expected -393216/0000",
                     $signed(best_energy), best_spins);
        end
        set_phases(ONE_P, ONE_P, ONE_P, ONE_P);
        do_start();
        wait_done(lat, bn);
        n_checks++;
        if (spins !== 4'b1111 || energy !== E_M6) begin
            n_fail++;
            $display("FAIL best_tie_run: got %0d/%b expected -393216/1111",
                     $signed(energy), spins);
        end
        n_checks++;
        if (best_energy !== E_M6 || best_spins !== 4'b0000) begin
            n_fail++;
            $display("FAIL best_tie_keeps_old: got %0d/%b expected -393216/0000",
                     $signed(best_energy), best_spins);
        end
        @(posedge clk); #1;
        clear_best = 1'b1;
        @(posedge clk); #1;
        clear_best = 1'b0;
        set_phases(0, ONE_P, 0, ONE_P);
        do_start();
        wait_done(lat, bn);
        n_checks++;
        if (best_energy !== E_P2 || best_spins !== 4'b1010) begin
            n_fail++;
            $display("FAIL best_after_clear: got %0d/%b expected 131072/1010",
                     $signed(best_energy), best_spins);
        end
    endtask
`endif

    initial begin
        rst   = 1'b1;
        start = 1'b0;
`ifdef ISING_BEST_TRACK_EN
        clear_best = 1'b0;
`endif
        set_phases(0, 0, 0, 0);
        set_j_all(ONE_P);
        test_reset();
        test_all_aligned();
        test_alternating();
        test_weighted();
        test_rounding();
        test_ignore_start();
        test_mid_reset();
`ifdef ISING_BEST_TRACK_EN
        test_best();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
